// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory and instruction-handoff signals of the
// fetch unit.
//   master (fetch unit): drives imem_en/imem_addr and ir_data/ir_pc/ir_valid;
//                        receives imem_rdata and ir_ready.
//   slave  (memory / execute side): the mirror image.
interface inst_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       ir_data;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    output imem_en, imem_addr, ir_data, ir_pc, ir_valid,
    input  imem_rdata, ir_ready
  );

  modport slave (
    input  imem_en, imem_addr, ir_data, ir_pc, ir_valid,
    output imem_rdata, ir_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit for the 16-bit GPR processor.
// Drives a synchronous instruction memory (1-cycle read latency), buffers
// returned words in a 2-entry {pc, word} queue and hands them to execute
// over a valid/ready handshake. Supports start, halt and PC redirect.
// Ports:
//   clk, sys_rst        clock, synchronous active-high reset
//   start/halt          begin fetching / stop issuing and drain
//   redirect/_pc        flush queue and in-flight read, load new PC
//   busy                state != IDLE
//   illegal             sticky illegal-opcode flag
//   bus (master)        imem_en/addr/rdata, ir_data/pc/valid/ready
// Optional feature macro: FETCH_OPCHECK_EN enables the opcode check; without
// it every word is accepted and illegal stays 0.
//
// state | meaning
// IDLE  | no fetching; waiting for start
// RUN   | issuing reads as queue space allows
// DRAIN | no new reads; waiting for queue and in-flight read to empty
module inst_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              illegal,
  inst_fetch_if.master      bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] qpc0_q, qpc0_d, qpc1_q, qpc1_d;
  logic [31:0]       qdat0_q, qdat0_d, qdat1_q, qdat1_d;
  logic              illegal_q, illegal_d;

  logic       pop, issue, push, word_bad, bad_hit;
  logic [2:0] occ;
  logic [1:0] cnt_after_pop;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    qpc0_d     = qpc0_q;
    qpc1_d     = qpc1_q;
    qdat0_d    = qdat0_q;
    qdat1_d    = qdat1_q;
    illegal_d  = illegal_q;

    pop = (count_q != 2'd0) && bus.ir_ready;
    // Slots already claimed after this cycle's pop; a new read needs one free.
    occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue = (state_q == S_RUN) && !halt && !redirect && (occ < 3'd2);
    inflight_d = issue;

`ifdef FETCH_OPCHECK_EN
    word_bad = bus.imem_rdata[31:27] > 5'b00100;
`else
    word_bad = 1'b0;
`endif

    // Once illegal is set, any later returning word is dropped.
    push    = inflight_q && !redirect && !illegal_q && !word_bad;
    bad_hit = inflight_q && !redirect && !illegal_q && word_bad;
    illegal_d = illegal_q || bad_hit;

    // Pop shifts the queue first; push then lands in the first free slot.
    cnt_after_pop = count_q - {1'b0, pop};
    if (pop) begin
      qpc0_d  = qpc1_q;
      qdat0_d = qdat1_q;
    end
    if (push) begin
      if (cnt_after_pop == 2'd0) begin
        qpc0_d  = pc_q - ADDR_W'(1);
        qdat0_d = bus.imem_rdata;
      end else begin
        qpc1_d  = pc_q - ADDR_W'(1);
        qdat1_d = bus.imem_rdata;
      end
    end
    count_d = cnt_after_pop + {1'b0, push};

    if (redirect) begin
      count_d = 2'd0;
      pc_d    = redirect_pc;
    end else if (issue) begin
      pc_d = pc_q + ADDR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start && !illegal_q) state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect && halt)      state_d = S_IDLE;
        else if (halt || bad_hit)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (redirect && halt)                          state_d = S_IDLE;
        else if (count_q == 2'd0 && !inflight_q)       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      qpc0_q     <= '0;
      qpc1_q     <= '0;
      qdat0_q    <= '0;
      qdat1_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      qpc0_q     <= qpc0_d;
      qpc1_q     <= qpc1_d;
      qdat0_q    <= qdat0_d;
      qdat1_q    <= qdat1_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc_q;
  assign bus.ir_data   = qdat0_q;
  assign bus.ir_pc     = qpc0_q;
  assign bus.ir_valid  = (count_q != 2'd0);
  assign busy          = (state_q != S_IDLE);
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  logic       clk = 1'b0;
  logic       sys_rst, start, halt, redirect;
  logic [7:0] redirect_pc;
  logic       busy, illegal;
  logic [31:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_if #(.ADDR_W(8)) bus ();

  inst_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .busy        (busy),
    .illegal     (illegal),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

  function automatic logic [31:0] word_of(input int a);
    if (a == 0) return 32'h0840_0005;
    return 32'h0840_0000 | (32'(a) << 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0;
    redirect_pc = 8'h00; bus.ir_ready = 1'b0;
    tick(); tick();
    sys_rst = 1'b0;
    tick();
  endtask

  // With ir_ready=1, expect n consecutive words starting at pc 'first'
  // within 'budget' samples; each sampled valid head pops on the next edge.
  task automatic drain_expect(input int n, input logic [7:0] first, input int budget);
    int got = 0;
    logic [7:0] e = first;
    for (int c = 0; c < budget && got < n; c++) begin
      if (bus.ir_valid) begin
        chk("drain_pc", 32'(bus.ir_pc), 32'(e));
        chk("drain_data", bus.ir_data, word_of(int'(e)));
        e = e + 8'd1;
        got++;
      end
      tick();
    end
    chk("drain_count", 32'(got), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen;
    logic en_seen;
    for (int i = 0; i < 256; i++) mem[i] = word_of(i);

    // Reset values
    sys_rst = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0;
    redirect_pc = 8'h00; bus.ir_ready = 1'b0;
    tick(); tick();
    chk("rst_imem_en", 32'(bus.imem_en), 0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 0);
    chk("rst_ir_valid", 32'(bus.ir_valid), 0);
    chk("rst_ir_data", bus.ir_data, 0);
    chk("rst_ir_pc", 32'(bus.ir_pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_illegal", 32'(illegal), 0);
    sys_rst = 1'b0;
    tick();

    // halt in IDLE is ignored
    halt = 1'b1; tick(); halt = 1'b0;
    chk("idle_halt_busy", 32'(busy), 0);

    // Start with ir_ready high: 2-cycle latency, then one word per cycle
    bus.ir_ready = 1'b1;
    start = 1'b1; #1;
    chk("pre_start_en", 32'(bus.imem_en), 0);
    tick(); start = 1'b0; #1;
    chk("start_en", 32'(bus.imem_en), 1);
    chk("start_addr", 32'(bus.imem_addr), 0);
    chk("start_busy", 32'(busy), 1);
    chk("start_valid0", 32'(bus.ir_valid), 0);
    tick();
    chk("start_valid1", 32'(bus.ir_valid), 0);
    chk("start_addr1", 32'(bus.imem_addr), 1);
    tick();
    chk("first_valid", 32'(bus.ir_valid), 1);
    chk("first_data", bus.ir_data, 32'h0840_0005);
    chk("first_pc", 32'(bus.ir_pc), 0);
    drain_expect(6, 8'h00, 6);
`ifndef FETCH_OPCHECK_EN
    chk("no_opcheck_illegal", 32'(illegal), 0);
`endif

    // Backpressure: queue fills, issue stops, head stable
    do_reset();
    chk("mid_run_rst_valid", 32'(bus.ir_valid), 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 2) begin
        chk("stall_en", 32'(bus.imem_en), 0);
        chk("stall_pc", 32'(bus.ir_pc), 0);
        chk("stall_data", bus.ir_data, 32'h0840_0005);
      end
    end
    chk("stall_addr", 32'(bus.imem_addr), 2);
    bus.ir_ready = 1'b1;
    drain_expect(3, 8'h00, 6);

    // Redirect with one queued and one in flight
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 8'h40; #1;
    chk("redir_en_blocked", 32'(bus.imem_en), 0);
    tick(); redirect = 1'b0; #1;
    chk("redir_valid", 32'(bus.ir_valid), 0);
    chk("redir_en", 32'(bus.imem_en), 1);
    chk("redir_addr", 32'(bus.imem_addr), 8'h40);
    bus.ir_ready = 1'b1;
    drain_expect(3, 8'h40, 8);

    // Redirect with a full queue to 0xFE: PC wraps 0xFF -> 0x00
    bus.ir_ready = 1'b0;
    tick(); tick(); tick(); tick();
    chk("full_valid", 32'(bus.ir_valid), 1);
    redirect = 1'b1; redirect_pc = 8'hFE;
    tick(); redirect = 1'b0;
    chk("wrap_flush_valid", 32'(bus.ir_valid), 0);
    bus.ir_ready = 1'b1;
    drain_expect(3, 8'hFE, 8);

    // halt mid-stream: no further reads, queue drains, busy falls
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    halt = 1'b1; #1;
    chk("halt_en", 32'(bus.imem_en), 0);
    tick(); halt = 1'b0; #1;
    chk("halt_busy", 32'(busy), 1);
    chk("halt_valid", 32'(bus.ir_valid), 1);
    chk("halt_en2", 32'(bus.imem_en), 0);
    bus.ir_ready = 1'b1;
    drain_expect(2, 8'h00, 4);
    en_seen = 1'b0;
    for (int i = 0; i < 4 && busy; i++) begin
      en_seen = en_seen | bus.imem_en;
      tick();
    end
    chk("drain_no_en", 32'(en_seen), 0);
    chk("drain_busy", 32'(busy), 0);
    chk("drain_valid", 32'(bus.ir_valid), 0);

    // Reset in the middle of DRAIN
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    halt = 1'b1; tick(); halt = 1'b0;
    chk("drain_state_busy", 32'(busy), 1);
    sys_rst = 1'b1; tick(); #1;
    chk("drst_valid", 32'(bus.ir_valid), 0);
    chk("drst_busy", 32'(busy), 0);
    chk("drst_pc", 32'(bus.ir_pc), 0);
    chk("drst_data", bus.ir_data, 0);
    chk("drst_addr", 32'(bus.imem_addr), 0);
    chk("drst_en", 32'(bus.imem_en), 0);
    sys_rst = 1'b0; tick();

    // start and halt together in IDLE: start wins
    start = 1'b1; halt = 1'b1; tick(); start = 1'b0; halt = 1'b0;
    chk("start_halt_busy", 32'(busy), 1);

`ifdef FETCH_OPCHECK_EN
    // Illegal opcode at PC 3
    mem[3] = 32'hF800_0000;
    do_reset();
    bus.ir_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    drain_expect(3, 8'h00, 10);
    seen = 0;
    for (int i = 0; i < 8 && busy; i++) begin
      if (bus.ir_valid) seen++;
      tick();
    end
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_busy", 32'(busy), 0);
    chk("ill_no_word", 32'(seen), 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("ill_start_ignored", 32'(busy), 0);
    chk("ill_sticky", 32'(illegal), 1);
    mem[3] = word_of(3);
`else
    seen = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
